// File: rtl/fwd_hazard_if.sv
// ID-stage request and EX-operand/stall response bundle between the pipeline
// control and the forwarding/hazard unit.
interface fwd_hazard_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_use_rs1;
   logic                  id_use_rs2;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_reg_write;
   logic                  id_mem_read;
   logic                  flush;
   logic                  hold;
   logic [1:0]            fwd_a_sel;
   logic [1:0]            fwd_b_sel;
   logic                  stall;
   logic [CNT_W-1:0]      stall_count;

   // The pipeline presents ID every cycle; there is no backpressure beyond
   // stall (ID must re-present the same instruction) and hold (nothing moves).
   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_reg_write, id_mem_read, flush, hold,
      input  fwd_a_sel, fwd_b_sel, stall, stall_count
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_reg_write, id_mem_read, flush, hold,
      output fwd_a_sel, fwd_b_sel, stall, stall_count
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Tracks EX/MEM destination registers, produces registered ALU operand-forward
// selects, detects load-use hazards and counts stall cycles (saturating).
module fwd_hazard_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   fwd_hazard_if.slave bus
);
   localparam logic [1:0] SEL_RF    = 2'b00;
   localparam logic [1:0] SEL_EXMEM = 2'b01;
   localparam logic [1:0] SEL_MEMWB = 2'b10;

   logic                  ex_valid_q, ex_valid_d;
   logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
   logic                  ex_reg_write_q, ex_reg_write_d;
   logic                  ex_mem_read_q, ex_mem_read_d;
   logic                  mem_valid_q, mem_valid_d;
   logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
   logic                  mem_reg_write_q, mem_reg_write_d;
   logic [1:0]            fwd_a_sel_q, fwd_a_sel_d;
   logic [1:0]            fwd_b_sel_q, fwd_b_sel_d;
   logic [CNT_W-1:0]      stall_count_q, stall_count_d;

   logic ex_prod_a, ex_prod_b, mem_prod_a, mem_prod_b;
   logic load_hit, stall_c, advance;
   logic [1:0] sel_a, sel_b;

   always_comb begin
      ex_prod_a  = bus.id_use_rs1 && ex_valid_q && ex_reg_write_q &&
                   (ex_rd_q == bus.id_rs1) && (bus.id_rs1 != '0);
      ex_prod_b  = bus.id_use_rs2 && ex_valid_q && ex_reg_write_q &&
                   (ex_rd_q == bus.id_rs2) && (bus.id_rs2 != '0);
      mem_prod_a = bus.id_use_rs1 && mem_valid_q && mem_reg_write_q &&
                   (mem_rd_q == bus.id_rs1) && (bus.id_rs1 != '0);
      mem_prod_b = bus.id_use_rs2 && mem_valid_q && mem_reg_write_q &&
                   (mem_rd_q == bus.id_rs2) && (bus.id_rs2 != '0);

      // The newest producer (EX) takes precedence over the older one (MEM).
      sel_a = ex_prod_a ? SEL_EXMEM : (mem_prod_a ? SEL_MEMWB : SEL_RF);
      sel_b = ex_prod_b ? SEL_EXMEM : (mem_prod_b ? SEL_MEMWB : SEL_RF);

      load_hit = ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) &&
                 ((bus.id_use_rs1 && (ex_rd_q == bus.id_rs1)) ||
                  (bus.id_use_rs2 && (ex_rd_q == bus.id_rs2)));
      stall_c  = bus.id_valid && !bus.flush && !bus.hold && load_hit;
      advance  = bus.id_valid && !stall_c && !bus.flush;
   end

   always_comb begin
      ex_valid_d      = ex_valid_q;
      ex_rd_d         = ex_rd_q;
      ex_reg_write_d  = ex_reg_write_q;
      ex_mem_read_d   = ex_mem_read_q;
      mem_valid_d     = mem_valid_q;
      mem_rd_d        = mem_rd_q;
      mem_reg_write_d = mem_reg_write_q;
      fwd_a_sel_d     = fwd_a_sel_q;
      fwd_b_sel_d     = fwd_b_sel_q;
      stall_count_d   = stall_count_q;

      if (!bus.hold) begin
         mem_valid_d     = ex_valid_q;
         mem_rd_d        = ex_rd_q;
         mem_reg_write_d = ex_reg_write_q;
         ex_valid_d      = advance;
         fwd_a_sel_d     = SEL_RF;
         fwd_b_sel_d     = SEL_RF;
         // A killed or stalled instruction leaves no trace in EX besides valid=0.
         if (advance) begin
            ex_rd_d        = bus.id_rd;
            ex_reg_write_d = bus.id_reg_write;
            ex_mem_read_d  = bus.id_mem_read;
            fwd_a_sel_d    = sel_a;
            fwd_b_sel_d    = sel_b;
         end
         if (stall_c && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid_q      <= 1'b0;
         ex_rd_q         <= '0;
         ex_reg_write_q  <= 1'b0;
         ex_mem_read_q   <= 1'b0;
         mem_valid_q     <= 1'b0;
         mem_rd_q        <= '0;
         mem_reg_write_q <= 1'b0;
         fwd_a_sel_q     <= SEL_RF;
         fwd_b_sel_q     <= SEL_RF;
         stall_count_q   <= '0;
      end else begin
         ex_valid_q      <= ex_valid_d;
         ex_rd_q         <= ex_rd_d;
         ex_reg_write_q  <= ex_reg_write_d;
         ex_mem_read_q   <= ex_mem_read_d;
         mem_valid_q     <= mem_valid_d;
         mem_rd_q        <= mem_rd_d;
         mem_reg_write_q <= mem_reg_write_d;
         fwd_a_sel_q     <= fwd_a_sel_d;
         fwd_b_sel_q     <= fwd_b_sel_d;
         stall_count_q   <= stall_count_d;
      end
   end

   assign bus.fwd_a_sel   = fwd_a_sel_q;
   assign bus.fwd_b_sel   = fwd_b_sel_q;
   assign bus.stall       = stall_c;
   assign bus.stall_count = stall_count_q;
endmodule
